// File: rtl/fetch_pc_if.sv
// Fetch PC unit bus: imem port, predictor feedback and IF/ID outputs.
// The fetch unit uses the master modport; the environment uses the slave side.
interface fetch_pc_if #(
   parameter int PERF_W = 32
);
   logic              stall;
   logic [31:0]       imem_rdata;
   logic              wrong;
   logic [31:0]       correct_pc;
   logic [31:0]       NPC4_f;
   logic              prediction;
   logic              jump;
   logic              branch;
   logic              hlt;
   logic [31:0]       imem_addr;
   logic [31:0]       instruction_pls;
   logic [31:0]       PC4;
   logic [31:0]       instr_d;
   logic [31:0]       pc4_d;
   logic              pred_taken_d;
   logic              valid_d;
   logic              halted;
   logic [PERF_W-1:0] perf_fetch;
   logic [PERF_W-1:0] perf_redirect;
   logic [PERF_W-1:0] perf_stall;

   modport master (
      input  stall, imem_rdata, wrong, correct_pc, NPC4_f,
      input  prediction, jump, branch, hlt,
      output imem_addr, instruction_pls, PC4,
      output instr_d, pc4_d, pred_taken_d, valid_d, halted,
      output perf_fetch, perf_redirect, perf_stall
   );

   modport slave (
      output stall, imem_rdata, wrong, correct_pc, NPC4_f,
      output prediction, jump, branch, hlt,
      input  imem_addr, instruction_pls, PC4,
      input  instr_d, pc4_d, pred_taken_d, valid_d, halted,
      input  perf_fetch, perf_redirect, perf_stall
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC select, HLT FSM and IF/ID register.
// Optional counters enabled by defining FETCH_PERF_EN.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PERF_W   = 32
) (
   input logic        clk,
   input logic        reset,
   fetch_pc_if.master bus
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] pc4_q;
   logic        taken_q;
   logic        valid_q;
   logic [31:0] pc4;
   logic        take;

   assign pc4  = pc_q + 32'd4;
   assign take = bus.jump | (bus.branch & bus.prediction);

   assign bus.imem_addr       = pc_q;
   assign bus.instruction_pls = bus.imem_rdata;
   assign bus.PC4             = pc4;
   assign bus.instr_d         = instr_q;
   assign bus.pc4_d           = pc4_q;
   assign bus.pred_taken_d    = taken_q;
   assign bus.valid_d         = valid_q;
   assign bus.halted          = (state_q == HALT);

   // PC, FSM and IF/ID register: redirect > stall > halt > hlt > taken > seq
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= '0;
         pc4_q   <= '0;
         taken_q <= 1'b0;
         valid_q <= 1'b0;
         state_q <= RUN;
      end else if (bus.wrong) begin
         pc_q    <= bus.correct_pc;
         taken_q <= 1'b0;
         valid_q <= 1'b0;
         state_q <= RUN;
      end else if (bus.stall) begin
         pc_q    <= pc_q;
      end else if (state_q == HALT) begin
         taken_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= bus.imem_rdata;
         pc4_q   <= pc4;
         valid_q <= 1'b1;
         if (bus.hlt) begin
            taken_q <= 1'b0;
            state_q <= HALT;
         end else if (take) begin
            pc_q    <= bus.NPC4_f;
            taken_q <= 1'b1;
         end else begin
            pc_q    <= pc4;
            taken_q <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

   logic [PERF_W-1:0] fetch_q;
   logic [PERF_W-1:0] redir_q;
   logic [PERF_W-1:0] stall_q;
   logic              capture;

   assign capture = ~bus.wrong & ~bus.stall & (state_q == RUN);

   assign bus.perf_fetch    = fetch_q;
   assign bus.perf_redirect = redir_q;
   assign bus.perf_stall    = stall_q;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_q <= '0;
         redir_q <= '0;
         stall_q <= '0;
      end else begin
         if (capture && fetch_q != '1)
            fetch_q <= fetch_q + ONE;
         if (bus.wrong && redir_q != '1)
            redir_q <= redir_q + ONE;
         if (bus.stall && !bus.wrong && stall_q != '1)
            stall_q <= stall_q + ONE;
      end
   end
`else
   assign bus.perf_fetch    = {PERF_W{1'b0}};
   assign bus.perf_redirect = {PERF_W{1'b0}};
   assign bus.perf_stall    = {PERF_W{1'b0}};
`endif

endmodule
